glyph_column_streamer: RTL and testbench

//  Converts an accepted character code into a stream of glyph columns for the WS2812B text path.

---
 rtl/glyph_pkg.sv | 42 ++++
 rtl/glyph_rom.sv | 36 +++
 rtl/glyph_column_streamer.sv | 171 +++++++++++++++++
 tb/tb_glyph_column_streamer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared types and helpers for the glyph column streamer.
// The built-in font table lives here as a constant function so the ROM
// contents come from one place and need no load step at elaboration.
package glyph_pkg;

    localparam int GLYPH_W_DEF    = 5;
    localparam int GLYPH_H_DEF    = 7;
    localparam int GLYPH_BITS_DEF = GLYPH_W_DEF * GLYPH_H_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Row-major, MSB-first bit position of pixel (r, c) inside a glyph word.
    function automatic int glyph_bit_idx(input int r, input int c,
                                         input int w = GLYPH_W_DEF,
                                         input int h = GLYPH_H_DEF);
        return w * h - 1 - (r * w + c);
    endfunction

    // Font image, one GLYPH_W*GLYPH_H word per code. Each 5-bit group is one
    // row, top row first, leftmost column in the group MSB. Unlisted codes
    // are blank. Code 0x05 carries a stripe pattern that the control-code
    // override must hide.
    function automatic logic [GLYPH_BITS_DEF-1:0] font_word(input int code);
        logic [GLYPH_BITS_DEF-1:0] w;
        w = '0;
        case (code)
            'h05: w = {5'b01010, 5'b10101, 5'b01010, 5'b10101,
                       5'b01010, 5'b10101, 5'b01010};
            'h4C: w = {5'b10000, 5'b10000, 5'b10000, 5'b10000,
                       5'b10000, 5'b10000, 5'b11111};
            'h54: w = {5'b11111, 5'b00100, 5'b00100, 5'b00100,
                       5'b00100, 5'b00100, 5'b00100};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/glyph_rom.sv
// Synchronous-read font ROM: address presented with en, word valid on the
// next cycle. Contents come from glyph_pkg::font_word.
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int CODE_W = 7,
    parameter int WORD_W = GLYPH_BITS_DEF
) (
    input  logic              clk,
    input  logic              en,
    input  logic [CODE_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    localparam int DEPTH = 2 ** CODE_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] data_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_font
            assign mem[gi] = WORD_W'(font_word(gi));
        end
    endgenerate

    // Registered read so the table maps onto block ROM.
    always_ff @(posedge clk) begin
        if (en) begin
            data_q <= mem[addr];
        end
    end

    assign data = data_q;

endmodule

// File: rtl/glyph_column_streamer.sv
// Character code in, glyph columns out (valid/ready on both sides).
// IDLE accepts a code, FETCH reads the font ROM and loads the glyph register,
// STREAM walks the column index forward or backward (mirror) one column per
// handshake. Build option GLYPH_SPACING_EN appends one all-zero spacer column
// that carries col_last.
module glyph_column_streamer
    import glyph_pkg::*;
#(
    parameter int GLYPH_W         = 5,
    parameter int GLYPH_H         = 7,
    parameter int CODE_W          = 7,
    parameter int FIRST_PRINTABLE = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               char_valid,
    output logic               char_ready,
    input  logic [CODE_W-1:0]  char_code,
    input  logic               mirror,
    output logic               col_valid,
    input  logic               col_ready,
    output logic [GLYPH_H-1:0] col_data,
    output logic               col_last,
    output logic               busy
);

    localparam int GBITS = GLYPH_W * GLYPH_H;
    localparam int BIT_W = $clog2(GBITS);
    localparam int IDX_W = $clog2(GLYPH_W + 1);

    localparam logic [IDX_W-1:0] IDX_FIRST = '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(GLYPH_W - 1);
`ifdef GLYPH_SPACING_EN
    // One past the last real column doubles as the spacer position.
    localparam logic [IDX_W-1:0] IDX_SPACER = IDX_W'(GLYPH_W);
`endif

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               mirror_q, mirror_d;
    logic [GBITS-1:0]   glyph_q, glyph_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               col_valid_q, col_valid_d;
    logic [GLYPH_H-1:0] col_data_q, col_data_d;
    logic               col_last_q, col_last_d;

    logic [GBITS-1:0]   rom_data;
    logic [IDX_W-1:0]   final_idx;

    // Extract one column of a glyph word; positions past the glyph are blank.
    function automatic logic [GLYPH_H-1:0] column_of(input logic [GBITS-1:0] g,
                                                     input logic [IDX_W-1:0] c);
        logic [GLYPH_H-1:0] col;
        col = '0;
        if (int'(c) < GLYPH_W) begin
            for (int r = 0; r < GLYPH_H; r++) begin
                col[r] = g[BIT_W'(glyph_bit_idx(r, int'(c), GLYPH_W, GLYPH_H))];
            end
        end
        return col;
    endfunction

    // Next column position; only called when the current column is not final.
    function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] i,
                                                  input logic mir);
`ifdef GLYPH_SPACING_EN
        if (mir) begin
            return (i == IDX_FIRST) ? IDX_SPACER : i - IDX_W'(1);
        end
        return (i == IDX_LAST) ? IDX_SPACER : i + IDX_W'(1);
`else
        return mir ? i - IDX_W'(1) : i + IDX_W'(1);
`endif
    endfunction

    glyph_rom #(
        .CODE_W (CODE_W),
        .WORD_W (GBITS)
    ) u_rom (
        .clk  (clk),
        .en   (char_valid && (state_q == ST_IDLE)),
        .addr (char_code),
        .data (rom_data)
    );

    // Column position that carries col_last for the glyph in progress.
`ifdef GLYPH_SPACING_EN
    assign final_idx = IDX_SPACER;
`else
    assign final_idx = mirror_q ? IDX_FIRST : IDX_LAST;
`endif

    // Next-state and next-output computation for the streaming FSM.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        mirror_d    = mirror_q;
        glyph_d     = glyph_q;
        idx_d       = idx_q;
        col_valid_d = col_valid_q;
        col_data_d  = col_data_q;
        col_last_d  = col_last_q;
        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    code_d   = char_code;
                    mirror_d = mirror;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                glyph_d     = (int'(code_q) < FIRST_PRINTABLE) ? '1 : rom_data;
                idx_d       = mirror_q ? IDX_LAST : IDX_FIRST;
                col_valid_d = 1'b1;
                col_data_d  = column_of(glyph_d, idx_d);
                col_last_d  = (idx_d == final_idx);
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (col_ready) begin
                    if (col_last_q) begin
                        col_valid_d = 1'b0;
                        col_data_d  = '0;
                        col_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d      = step_idx(idx_q, mirror_q);
                        col_data_d = column_of(glyph_q, idx_d);
                        col_last_d = (idx_d == final_idx);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                col_valid_d = 1'b0;
                col_data_d  = '0;
                col_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any glyph in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            mirror_q    <= 1'b0;
            glyph_q     <= '0;
            idx_q       <= '0;
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
            col_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            mirror_q    <= mirror_d;
            glyph_q     <= glyph_d;
            idx_q       <= idx_d;
            col_valid_q <= col_valid_d;
            col_data_q  <= col_data_d;
            col_last_q  <= col_last_d;
        end
    end

    assign char_ready = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign col_valid  = col_valid_q;
    assign col_data   = col_data_q;
    assign col_last   = col_last_q;

endmodule

// File: tb/tb_glyph_column_streamer.sv
// Bench for glyph_column_streamer: a per-cycle reference model built from
// font rows, plus directed glyphs checked against hand-written column lists.
`timescale 1ns/1ps
module tb_glyph_column_streamer;

    localparam int W = 5;
    localparam int H = 7;
`ifdef GLYPH_SPACING_EN
    localparam int SPACE = 1;
`else
    localparam int SPACE = 0;
`endif
    localparam int NCOL = W + SPACE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic [6:0] char_code = 7'h00;
    logic       mirror = 1'b0;
    logic       col_valid;
    logic       col_ready = 1'b1;
    logic [6:0] col_data;
    logic       col_last;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit checking = 1'b0;

    glyph_column_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_code  (char_code),
        .mirror     (mirror),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_data   (col_data),
        .col_last   (col_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] font_row(input int code, input int r);
        if (code < 32) return 5'b11111;
        case (code)
            'h4C: return (r == 6) ? 5'b11111 : 5'b10000;
            'h54: return (r == 0) ? 5'b11111 : 5'b00100;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [6:0] model_col(input int code, input int c);
        logic [6:0] col;
        logic [4:0] row;
        col = '0;
        for (int r = 0; r < H; r++) begin
            row = font_row(code, r);
            col[r] = row[W-1-c];
        end
        return col;
    endfunction

    logic [6:0] q_data[$];
    bit         q_last[$];
    bit         m_busy = 1'b0;
    int         m_delay = 0;
    bit         exp_valid;

    task automatic model_push(input int code, input bit mir);
        for (int k = 0; k < W; k++) begin
            q_data.push_back(model_col(code, mir ? (W - 1 - k) : k));
            q_last.push_back((SPACE == 0) && (k == W - 1));
        end
        if (SPACE != 0) begin
            q_data.push_back(7'h00);
            q_last.push_back(1'b1);
        end
    endtask

    // Every-cycle comparison against the model, then advance the model to
    // what the coming clock edge will do.
    always @(negedge clk) begin
        if (checking) begin
            exp_valid = m_busy && (m_delay == 0);
            chk("char_ready", char_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("col_valid", col_valid, exp_valid);
            if (exp_valid && col_valid) begin
                chk("col_data", col_data, q_data[0]);
                chk("col_last", col_last, q_last[0]);
            end
            if (rst) begin
                q_data.delete();
                q_last.delete();
                m_busy  = 1'b0;
                m_delay = 0;
            end else if (m_busy) begin
                if (m_delay > 0) begin
                    m_delay--;
                end else if (col_ready) begin
                    void'(q_data.pop_front());
                    void'(q_last.pop_front());
                    if (q_data.size() == 0) m_busy = 1'b0;
                end
            end else if (char_valid) begin
                model_push(int'(char_code), mirror);
                m_busy  = 1'b1;
                m_delay = 1;
            end
        end
    end

    // ---------------- column capture ----------------
    logic [6:0] got_d[$];
    bit         got_l[$];
    int         got_c[$];

    always @(negedge clk) begin
        if (!rst && col_valid && col_ready) begin
            got_d.push_back(col_data);
            got_l.push_back(col_last);
            got_c.push_back(cyc);
        end
    end

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
        got_c.delete();
    endtask

    task automatic send(input logic [6:0] code, input bit mir);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        char_valid = 1'b1;
        char_code  = code;
        mirror     = mir;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (char_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_%0h: char_ready stayed low for 50 cycles", code);
        end
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_code  = 7'h00;
        mirror     = ~mir;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (char_ready && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL wait_idle: block not idle after 100 cycles");
        end
    endtask

    // exp5 lists the five glyph columns in emitted order, first in the top 7 bits.
    task automatic got_check(input string nm, input logic [34:0] exp5, input bit timing);
        logic [6:0] ed;
        chk({nm, " count"}, got_d.size(), NCOL);
        for (int i = 0; i < NCOL && i < got_d.size(); i++) begin
            ed = (i < W) ? 7'(exp5 >> (7 * (W - 1 - i))) : 7'h00;
            chk($sformatf("%s col%0d data", nm, i), got_d[i], ed);
            chk($sformatf("%s col%0d last", nm, i), got_l[i], (i == NCOL - 1));
        end
        if (timing && got_d.size() == NCOL) begin
            chk({nm, " first latency"}, got_c[0] - acc_cyc, 2);
            chk({nm, " last column cycle"}, got_c[NCOL-1] - acc_cyc, W + SPACE + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset char_ready", char_ready, 1'b1);
        chk("reset col_valid", col_valid, 1'b0);
        chk("reset col_data", col_data, 7'h00);
        chk("reset col_last", col_last, 1'b0);
        chk("reset busy", busy, 1'b0);
        checking = 1'b1;

        // L, normal order
        clear_got(); send(7'h4C, 1'b0); wait_idle();
        got_check("L_normal", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);

        // L, mirrored
        clear_got(); send(7'h4C, 1'b1); wait_idle();
        got_check("L_mirror", {7'h40, 7'h40, 7'h40, 7'h40, 7'h7F}, 1'b1);

        // control code with a non-blank ROM entry
        clear_got(); send(7'h05, 1'b0); wait_idle();
        got_check("ctrl_05", {5{7'h7F}}, 1'b1);

        // last control code before the printable range
        clear_got(); send(7'h1F, 1'b1); wait_idle();
        got_check("ctrl_1F", {5{7'h7F}}, 1'b1);

        // first printable code (space, blank in the font)
        clear_got(); send(7'h20, 1'b0); wait_idle();
        got_check("space_20", 35'h0, 1'b1);

        // T
        clear_got(); send(7'h54, 1'b0); wait_idle();
        got_check("T_normal", {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01}, 1'b1);

        // backpressure on column 1 for three cycles
        clear_got(); send(7'h4C, 1'b0);
        @(posedge clk);
        @(posedge clk); #1 col_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall col_valid", col_valid, 1'b1);
            chk("stall col_data", col_data, 7'h40);
            chk("stall col_last", col_last, 1'b0);
            chk("stall char_ready", char_ready, 1'b0);
        end
        @(posedge clk); #1 col_ready = 1'b1;
        wait_idle();
        got_check("L_stall", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);

        // reset while column 2 is on the output
        clear_got(); send(7'h4C, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort col_valid", col_valid, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort char_ready", char_ready, 1'b1);
        chk("abort columns before reset", got_d.size(), 2);
        clear_got(); send(7'h4C, 1'b0); wait_idle();
        got_check("L_after_abort", {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
